// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared width, counter width and FSM state encodings for the divider
package seq_divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring shift-subtract step
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_dvs,
  output logic [W:0]   o_rem,
  output logic         o_q
);
  logic [W:0] w_sh;
  logic [W:0] w_trial;
  assign w_sh = {i_rem[W-1:0], i_bit};
  assign w_trial = w_sh - {1'b0, i_dvs};
  // A set top bit means the true shifted value exceeds W+1 bits, so the trial cannot go negative
  assign o_q = i_rem[W] | ~w_trial[W];
  assign o_rem = o_q ? w_trial : w_sh;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider, one quotient bit per cycle
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_sgn_q, r_sgn_r, r_zero, r_done, r_dbz;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_raw, r_q, r_r;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_rem;
  logic             w_q, w_neg_a, w_neg_b;
  assign w_neg_a = i_signed & i_dividend[WIDTH-1];
  assign w_neg_b = i_signed & i_divisor[WIDTH-1];
  div_step #(.W(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_rem),
    .o_q   (w_q)
  );
  // The dividend register doubles as the quotient shift register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_raw   <= '0;
      r_sgn_q <= 1'b0;
      r_sgn_r <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= r_state == FIX;
      if (r_state == IDLE && i_start) begin
        r_state <= CALC;
        r_cnt   <= '0;
        r_rem   <= '0;
        r_dvd   <= w_neg_a ? -i_dividend : i_dividend;
        r_dvs   <= w_neg_b ? -i_divisor : i_divisor;
        r_raw   <= i_dividend;
        r_sgn_q <= w_neg_a ^ w_neg_b;
        r_sgn_r <= w_neg_a;
        r_zero  <= i_divisor == '0;
        r_dbz   <= 1'b0;
      end else if (r_state == CALC) begin
        r_rem <= w_rem;
        r_dvd <= {r_dvd[WIDTH-2:0], w_q};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
      end else if (r_state == FIX) begin
        r_state <= IDLE;
        r_q     <= r_zero ? '1 : (r_sgn_q ? -r_dvd : r_dvd);
        r_r     <= r_zero ? r_raw : (r_sgn_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);
        r_dbz   <= r_zero;
      end
    end
  end
  assign o_quotient    = r_q;
  assign o_remainder   = r_r;
  assign o_busy        = r_state != IDLE;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed scoreboard bench for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst, start, sgn;
  logic [31:0] a, b;
  logic [31:0] q, r;
  logic        busy, done, dbz;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int seen;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          k;
  } exp_t;
  exp_t sb[$];

  seq_divider dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_signed      (sgn),
    .i_dividend    (a),
    .i_divisor     (b),
    .o_quotient    (q),
    .o_remainder   (r),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive START for one cycle from a negedge; optionally push the expected result
  task automatic go(input logic s, input logic [31:0] x, input logic [31:0] y, input bit track);
    exp_t e;
    start = 1'b1;
    sgn = s;
    a = x;
    b = y;
    if (track) begin
      if (y == 32'd0) begin
        e.q = 32'hFFFFFFFF; e.r = x; e.z = 1'b1;
      end else if (s && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        e.q = 32'h80000000; e.r = 32'd0; e.z = 1'b0;
      end else if (s) begin
        e.q = $signed(x) / $signed(y); e.r = $signed(x) % $signed(y); e.z = 1'b0;
      end else begin
        e.q = x / y; e.r = x % y; e.z = 1'b0;
      end
      e.k = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sgn = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    else if (sb.size() == 0) chk({tag, "_unexpected_done"}, 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_dbz"}, 32'(dbz), 32'(e.z));
      chk({tag, "_latency"}, 32'(cyc - e.k), 32'd33);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    go(1'b0, 32'd100, 32'd7, 1'b1);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done("u100_7");
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("q_hold", q, 32'd14);
    go(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done("s_m7_2");
    go(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
    wait_done("s_7_m2");
    go(1'b0, 32'd5, 32'd0, 1'b1);
    wait_done("u5_0");
    go(1'b0, 32'd9, 32'd3, 1'b1);
    chk("dbz_clear_on_start", 32'(dbz), 32'd0);
    chk("q_hold_busy", q, 32'hFFFFFFFF);
    wait_done("u9_3");
    go(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done("s_ovf");
    go(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
    wait_done("u_max_1");
    go(1'b1, 32'hFFFFFF00, 32'd0, 1'b1);
    wait_done("s_neg_0");
    go(1'b0, 32'd50, 32'd5, 1'b1);
    repeat (9) @(negedge clk);
    chk("busy_mid", 32'(busy), 32'd1);
    go(1'b0, 32'd99, 32'd3, 1'b0);
    wait_done("ignored_start");
    go(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1);
    wait_done("b2b_0");
    for (int i = 0; i < 3; i++) begin
      go(1'b1, $urandom, $urandom_range(1, 2000) * (i == 1 ? -1 : 1), 1'b1);
      wait_done($sformatf("b2b_rand%0d", i));
    end
    go(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", q, 32'd0);
    chk("abort_r", r, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    rst = 1'b1; start = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_wins_start", 32'(busy), 32'd0);
    go(1'b0, 32'd100, 32'd7, 1'b1);
    wait_done("after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
